// File: rtl/time_keeper_pkg.sv
// Shared constants for the time keeper: field-select codes, reset time,
// week length and a small integer-to-BCD helper.
package time_keeper_pkg;

  typedef enum logic [1:0] {
    SEL_MIN  = 2'd0,
    SEL_HR   = 2'd1,
    SEL_DAY  = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  localparam int RST_HOUR      = 12;
  localparam int RST_MIN       = 0;
  localparam int RST_DAY       = 0;
  localparam int DAYS_PER_WEEK = 7;

  function automatic logic [7:0] to_bcd(input int n);
    to_bcd = {4'(n / 10), 4'(n % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MINIMUM..MINIMUM+MODULUS-1.
// Ports: clk, rst (async high), en; val (current), nxt (next), wrap (en at max).
module bcd_mod_counter
  import time_keeper_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int MINIMUM = 0,
  parameter int RST_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] val,
  output logic [7:0] nxt,
  output logic       wrap
);

  localparam logic [7:0] MAX_BCD = to_bcd(MINIMUM + MODULUS - 1);
  localparam logic [7:0] MIN_BCD = to_bcd(MINIMUM);
  localparam logic [7:0] RST_BCD = to_bcd(RST_VAL);

  logic [7:0] val_q;
  logic [7:0] val_d;

  always_comb begin
    val_d = val_q;
    wrap  = en && (val_q == MAX_BCD);
    if (en) begin
      if (wrap)
        val_d = MIN_BCD;
      else if (val_q[3:0] == 4'd9)
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      else
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= RST_BCD;
    else     val_q <= val_d;
  end

  assign val = val_q;
  assign nxt = val_d;

endmodule

// File: rtl/time_keeper.sv
// 12-hour clock with day of week, settable alarm and minute/alarm pulses.
// Ports: Clk, Clr, Tick, SetTime, SetAlarm, Sel, Inc, AlarmEn in;
// hr1/hr0/min1/min0/day/pm display and MinPulse/AlarmHit pulses out.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       SetTime,
  input  logic       SetAlarm,
  input  logic [1:0] Sel,
  input  logic       Inc,
  input  logic       AlarmEn,
  output logic       hr1,
  output logic [3:0] hr0,
  output logic [2:0] min1,
  output logic [3:0] min0,
  output logic [2:0] day,
  output logic       pm,
  output logic       MinPulse,
  output logic       AlarmHit
);

  localparam logic [5:0] SEC_MAX = 6'(TICKS_PER_MIN - 1);
  localparam logic [7:0] HR_11   = to_bcd(11);
  localparam logic [2:0] DAY_MAX = 3'(DAYS_PER_WEEK - 1);

  logic [5:0] sec_q, sec_d;
  logic       t_pm_q, t_pm_d;
  logic       a_pm_q, a_pm_d;
  logic [2:0] day_q, day_d;
  logic       min_pulse_q, min_pulse_d;
  logic       alarm_hit_q, alarm_hit_d;

  logic       set_alarm;
  logic       sec_wrap;
  logic       t_min_en, t_hr_en, a_min_en, a_hr_en, day_en;
  logic [7:0] t_min, t_min_nxt, t_hr, t_hr_nxt;
  logic [7:0] a_min, a_min_nxt, a_hr, a_hr_nxt;
  logic       t_min_wrap, t_hr_wrap, a_min_wrap, a_hr_wrap;

  assign set_alarm = SetAlarm & ~SetTime;
  assign sec_wrap  = ~SetTime & Tick & (sec_q == SEC_MAX);

  // Manual edits wrap within their field; only Tick carries ripple.
  assign t_min_en = sec_wrap
                  | (SetTime & Inc & (Sel == SEL_MIN));
  assign t_hr_en  = (sec_wrap & t_min_wrap)
                  | (SetTime & Inc & (Sel == SEL_HR));
  assign day_en   = (sec_wrap & t_min_wrap & (t_hr == HR_11) & t_pm_q)
                  | (SetTime & Inc & (Sel == SEL_DAY));
  assign a_min_en = set_alarm & Inc & (Sel == SEL_MIN);
  assign a_hr_en  = set_alarm & Inc & (Sel == SEL_HR);

  bcd_mod_counter #(.MODULUS(60), .MINIMUM(0), .RST_VAL(RST_MIN)) u_t_min (
    .clk(Clk), .rst(Clr), .en(t_min_en),
    .val(t_min), .nxt(t_min_nxt), .wrap(t_min_wrap)
  );

  bcd_mod_counter #(.MODULUS(12), .MINIMUM(1), .RST_VAL(RST_HOUR)) u_t_hr (
    .clk(Clk), .rst(Clr), .en(t_hr_en),
    .val(t_hr), .nxt(t_hr_nxt), .wrap(t_hr_wrap)
  );

  bcd_mod_counter #(.MODULUS(60), .MINIMUM(0), .RST_VAL(RST_MIN)) u_a_min (
    .clk(Clk), .rst(Clr), .en(a_min_en),
    .val(a_min), .nxt(a_min_nxt), .wrap(a_min_wrap)
  );

  bcd_mod_counter #(.MODULUS(12), .MINIMUM(1), .RST_VAL(RST_HOUR)) u_a_hr (
    .clk(Clk), .rst(Clr), .en(a_hr_en),
    .val(a_hr), .nxt(a_hr_nxt), .wrap(a_hr_wrap)
  );

  always_comb begin
    sec_d = sec_q;
    if (SetTime)
      sec_d = '0;
    else if (Tick)
      sec_d = sec_wrap ? '0 : sec_q + 6'd1;

    t_pm_d = t_pm_q ^ (t_hr_en & (t_hr == HR_11));
    a_pm_d = a_pm_q ^ (a_hr_en & (a_hr == HR_11));

    day_d = day_q;
    if (day_en)
      day_d = (day_q == DAY_MAX) ? '0 : day_q + 3'd1;

    min_pulse_d = sec_wrap;
    // Compare post-edge time against post-edge alarm.
    alarm_hit_d = sec_wrap & AlarmEn
                & (t_min_nxt == a_min_nxt)
                & (t_hr_nxt == a_hr_nxt)
                & (t_pm_d == a_pm_d);
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      sec_q       <= '0;
      t_pm_q      <= 1'b0;
      a_pm_q      <= 1'b0;
      day_q       <= 3'(RST_DAY);
      min_pulse_q <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      t_pm_q      <= t_pm_d;
      a_pm_q      <= a_pm_d;
      day_q       <= day_d;
      min_pulse_q <= min_pulse_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  always_comb begin
    if (set_alarm) begin
      hr1  = a_hr[4];
      hr0  = a_hr[3:0];
      min1 = a_min[6:4];
      min0 = a_min[3:0];
      pm   = a_pm_q;
    end else begin
      hr1  = t_hr[4];
      hr0  = t_hr[3:0];
      min1 = t_min[6:4];
      min0 = t_min[3:0];
      pm   = t_pm_q;
    end
  end

  assign day      = day_q;
  assign MinPulse = min_pulse_q;
  assign AlarmHit = alarm_hit_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, t_hr_wrap, a_min_wrap, a_hr_wrap,
                         t_hr[7:5], a_hr[7:5], t_min[7], a_min[7]};

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter TICKS_PER_MIN, default 60, giving the number of Tick strobes per minute (2..63).
REQ-002 SHALL have port Clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Clr  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port Tick  input  1  one-cycle timebase strobe (1 Hz in product).
REQ-005 SHALL have port SetTime  input  1  level; time-set mode.
REQ-006 SHALL have port SetAlarm  input  1  level; alarm-set mode.
REQ-007 SHALL have port Sel  input  2  field select: 0 minutes, 1 hours, 2 day, 3 none.
REQ-008 SHALL have port Inc  input  1  one-cycle increment of the selected field.
REQ-009 SHALL have port AlarmEn  input  1  level; arms alarm compare.
REQ-010 SHALL have ports hr1 (output, 1), hr0 (output, 4), min1 (output, 3), min0 (output, 4): displayed BCD hh:mm.
REQ-011 SHALL have port day  output  3  day of week, 0 = Sun .. 6 = Sat.
REQ-012 SHALL have port pm  output  1  displayed PM flag.
REQ-013 SHALL have port MinPulse  output  1  one-cycle pulse on every Tick-driven minute rollover.
REQ-014 SHALL have port AlarmHit  output  1  one-cycle alarm match pulse to the sound control unit.

Function
REQ-015 SHALL hold time in 12-hour format: hours 1..12 BCD, minutes 00..59 BCD, seconds 0..TICKS_PER_MIN-1 binary, pm flag, day.
REQ-016 SHALL present the alarm hh:mm/pm on the display outputs while SetAlarm=1 and SetTime=0; otherwise it SHALL present the time; day always shows time-day; the output path is combinational from registers.
REQ-017 Run mode (SetTime=0): on Tick, seconds SHALL increment; at TICKS_PER_MIN-1 they SHALL wrap to 0 and carry into minutes.
REQ-018 Minute carry: 59->00 SHALL carry into hours; hours 11->12 SHALL toggle pm; 12->1 SHALL NOT toggle pm.
REQ-019 The transition 11:59 PM -> 12:00 AM SHALL increment day, with 6 wrapping to 0.
REQ-020 MinPulse SHALL assert in the cycle after the edge that updates the minute registers on a Tick carry.
REQ-021 SetTime=1: seconds SHALL be held at 0; Tick SHALL be ignored; Inc SHALL increment the time field chosen by Sel.
REQ-022 SetAlarm=1 with SetTime=0: Inc SHALL increment the alarm field chosen by Sel; Sel=2 and Sel=3 SHALL be ignored; Tick counting continues.
REQ-023 Manual increments SHALL wrap with no carry: minutes 59->00; hours 12->1; day 6->0; hours 11->12 SHALL still toggle the pm flag of that register set.
REQ-024 Inc SHALL be ignored when both SetTime and SetAlarm are 0, and when Sel=3; SetTime SHALL take priority over SetAlarm.
REQ-025 On deassertion of SetTime, counting SHALL resume from seconds 0 on the next Tick.
REQ-026 AlarmHit SHALL pulse for one cycle, coincident with MinPulse, only when:
- AlarmEn=1;
- a Tick-driven rollover makes time hh:mm/pm equal to alarm hh:mm/pm.
REQ-027 Manual edits SHALL never produce AlarmHit or MinPulse.
REQ-028 Every result SHALL be visible on the outputs in the cycle after the causing Tick or Inc edge (latency 1).

Reset
REQ-029 While Clr=1 and immediately on its assertion, the block SHALL force:
- time to 12:00, seconds 0, pm=0, day=0;
- alarm to 12:00 AM;
- MinPulse=0, AlarmHit=0.
REQ-030 Clr asserted mid-increment or mid-rollover SHALL discard the operation; no pulse SHALL follow release.

Structure
REQ-031 A shared package time_keeper_pkg SHALL hold:
- the Sel encodings;
- reset constants (hour 12, minute 0, day 0);
- the day-count constant 7.
REQ-032 SHALL instantiate sub-module bcd_mod_counter (BCD count, modulus and minimum parameters, enable in, wrap/carry out) for minute and hour fields of both time and alarm.

Verification
REQ-033 Reset then 60 Ticks (TICKS_PER_MIN=60) -> time 12:01 AM, day 0, MinPulse exactly once.
REQ-034 Set time to 11:59 PM, day 6, release SetTime, 60 Ticks -> 12:00 AM, day 0, one MinPulse.
REQ-035 SetTime=1, Sel=1, Inc x11 from 12 AM -> 11 AM; one more Inc -> 12 PM; day unchanged; no MinPulse.
REQ-036 Alarm 12:02 AM, AlarmEn=1, 120 Ticks from reset -> single AlarmHit with the 12:02 update; repeat with AlarmEn=0 -> none.
REQ-037 SetTime=1 and SetAlarm=1, Sel=0, Inc -> time minutes 00->01, alarm unchanged; Clr pulsed mid-run -> all outputs at reset values immediately.
